serial_bus_master: RTL and testbench
====================================

// Module: serial_bus_master
// PURPOSE
//  Initiator end of the serial memory bus: takes one parallel read/write command, serialises
//  slave ID, address and write data onto data_bus_serial, handshakes on slave_busy, and
//  deserialises read data back to a parallel word. One instance per bus; slaves hang off the shared lines.
// PARAMETERS
//  ADDRESS_WIDTH   15   address field width, bits
//  DATA_WIDTH      8    data field width, bits
//  RX_LATENCY      2    cycles from handshake pulse to first sampled read-data bit (>=1)
//  TIMEOUT_CYCLES  255  max cycles waited on slave_busy / read data before abort
// PORTS
//  clk              in     1   clock, rising edge
//  rstn             in     1   asynchronous active-low reset
//  start            in     1   command strobe, sampled only in IDLE
//  cmd_rd_wrt       in     1   1 = write, 0 = read
//  cmd_slave_id     in     2   target slave ID
//  cmd_addr         in     ADDRESS_WIDTH  target address
//  cmd_wr_data      in     DATA_WIDTH     write data
//  busy             out    1   high from accepted start until done/timeout cycle inclusive
//  done             out    1   1-cycle pulse: transaction finished OK
//  timeout_err      out    1   1-cycle pulse: transaction aborted on timeout
//  rd_data          out    DATA_WIDTH     read result, valid from done pulse until next start
//  bus_req          out    1   bus request, 1-cycle pulse opening a transaction
//  rd_wrt           out    1   direction to slaves, held for whole transaction
//  data_bus_serial  inout  1   serial data, master drives only in TX phases else Z
//  slave_busy       inout  1   busy line; undriven reads 0 (board pull-down)
// BEHAVIOUR
//  Reset: busy/done/timeout_err/bus_req/rd_wrt=0, rd_data=0, both inouts Z, state IDLE; immediate,
//   also mid-transaction (lines released same cycle, no done/timeout pulse, command discarded).
//  States: IDLE, REQ, TX_SID, TX_ADDR, TX_DATA, WAIT_WR, WAIT_RD, HANDSHAKE, RX_DATA, FINISH.
//  IDLE: start=1 -> latch cmd_*, busy=1, rd_wrt=cmd_rd_wrt, go REQ. start outside IDLE ignored.
//  REQ (cycle T0): bus_req=1 for this cycle only -> TX_SID.
//  TX_SID/TX_ADDR/TX_DATA: one bit per cycle, MSB first, no gaps; SID bits on T1..T2, address on
//   T3..T(2+ADDRESS_WIDTH), write data on the next DATA_WIDTH cycles (write only).
//   Read skips TX_DATA. Bit counter width $clog2(max field)+1; reloads per field.
//  After last TX bit: data_bus_serial -> Z next cycle.
//  WAIT_WR: wait slave_busy==0 sampled -> FINISH (done). WAIT_RD: wait slave_busy==0 -> HANDSHAKE.
//  HANDSHAKE: drive slave_busy=1 exactly one cycle, then Z; -> RX_DATA.
//  RX_DATA: skip RX_LATENCY-1 cycles, then sample DATA_WIDTH consecutive bits MSB first into
//   shift register; after last bit copy to rd_data -> FINISH.
//  FINISH: done=1, busy=1 this cycle; next cycle IDLE, busy=0. Back-to-back start accepted
//   on the first IDLE cycle.
//  Timeout: counter clears on entering WAIT_WR/WAIT_RD/RX_DATA; reaching TIMEOUT_CYCLES with
//   condition unmet -> timeout_err pulse (1 cycle), rd_data unchanged, all lines Z, -> IDLE.
//  slave_busy already 0 on entry to a WAIT state -> proceeds next cycle (no minimum wait).
//  X/Z on slave_busy treated as 0.
// TESTING
//  Write id=2'b10 addr=15'h1234 data=8'hA5 -> bus_req pulse T0; serial bits T1..T25 =
//   10,001001000110100,10100101; slave_busy low 3 cycles later -> done one cycle after, busy drops.
//  Read id=2'b01 addr=15'h0007, model slave returns 8'h3C -> one-cycle slave_busy=1 drive after
//   slave releases; rd_data=8'h3C with done; data_bus_serial Z throughout receive.
//  Read with slave_busy held 1 forever -> timeout_err after 255 wait cycles, no done, rd_data
//   unchanged, lines Z.
//  rstn low during TX_ADDR bit 5 -> bus_req/rd_wrt 0, data_bus_serial Z same cycle; after
//   release a fresh write completes normally.
//  start pulsed during TX_SID and in FINISH cycle -> ignored (one bus_req only); start on
//   first IDLE cycle after done -> accepted, bus_req next cycle.
//  Write with slave_busy already 0 at WAIT_WR entry -> done exactly one cycle later.

Source files
------------

// File: rtl/serial_bus_master.sv
// rtl/serial_bus_master.sv - serial memory bus initiator: command serialiser, busy handshake, read deserialiser
//
// Ports:
//   clk, rstn                 clock (rising edge), asynchronous active-low reset
//   start                     command strobe, only looked at while idle
//   cmd_rd_wrt                1 = write, 0 = read
//   cmd_slave_id/addr/wr_data command fields, latched on an accepted start
//   busy                      high from accepted start through the done/timeout cycle
//   done, timeout_err         one-cycle completion / abort pulses
//   rd_data                   read result, updated together with the done pulse
//   bus_req                   one-cycle pulse opening a bus transaction
//   rd_wrt                    direction to the slaves, held for the whole transaction
//   data_bus_serial           shared serial data line, driven only while shifting out
//   slave_busy                shared busy line, driven only for the one-cycle handshake
module serial_bus_master #(
    parameter int ADDRESS_WIDTH  = 15,
    parameter int DATA_WIDTH     = 8,
    parameter int RX_LATENCY     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic                     cmd_rd_wrt,
    input  logic [1:0]               cmd_slave_id,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     bus_req,
    output logic                     rd_wrt,
    inout  wire                      data_bus_serial,
    inout  wire                      slave_busy
);

    localparam int FIELD_MAX = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
    localparam int BC_W      = $clog2(FIELD_MAX) + 1;
    localparam int RX_LAST   = RX_LATENCY - 1 + DATA_WIDTH - 1;
    localparam int CNT_MAX   = (TIMEOUT_CYCLES > RX_LAST + 1) ? TIMEOUT_CYCLES : RX_LAST + 1;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        IDLE, REQ, TX_SID, TX_ADDR, TX_DATA, WAIT_WR, WAIT_RD, HANDSHAKE, RX_DATA, FINISH
    } state_t;

    state_t                    state;
    logic [1:0]                sid_sh;
    logic [ADDRESS_WIDTH-1:0]  addr_sh;
    logic [DATA_WIDTH-1:0]     data_sh;
    logic [BC_W-1:0]           bit_cnt;
    logic [CNT_W-1:0]          cnt;
    logic [DATA_WIDTH-2:0]     rx_sh;
    logic [DATA_WIDTH-1:0]     rx_next;
    logic                      sdo;
    logic                      sdo_en;
    logic                      sb_drv;

    assign data_bus_serial = sdo_en ? sdo : 1'bz;
    assign slave_busy      = sb_drv ? 1'b1 : 1'bz;

    // Word as it stands once the bit currently on the line is shifted in.
    assign rx_next = {rx_sh, data_bus_serial};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            bus_req     <= 1'b0;
            rd_wrt      <= 1'b0;
            rd_data     <= '0;
            sid_sh      <= '0;
            addr_sh     <= '0;
            data_sh     <= '0;
            bit_cnt     <= '0;
            cnt         <= '0;
            rx_sh       <= '0;
            sdo         <= 1'b0;
            sdo_en      <= 1'b0;
            sb_drv      <= 1'b0;
        end else begin
            bus_req     <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    // busy may still be high here for the timeout pulse cycle.
                    busy <= 1'b0;
                    if (start) begin
                        sid_sh  <= cmd_slave_id;
                        addr_sh <= cmd_addr;
                        data_sh <= cmd_wr_data;
                        rd_wrt  <= cmd_rd_wrt;
                        busy    <= 1'b1;
                        bus_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    sdo     <= sid_sh[1];
                    sid_sh  <= sid_sh << 1;
                    sdo_en  <= 1'b1;
                    bit_cnt <= BC_W'(1);
                    state   <= TX_SID;
                end
                TX_SID: begin
                    if (bit_cnt == '0) begin
                        sdo     <= addr_sh[ADDRESS_WIDTH-1];
                        addr_sh <= addr_sh << 1;
                        bit_cnt <= BC_W'(ADDRESS_WIDTH - 1);
                        state   <= TX_ADDR;
                    end else begin
                        sdo     <= sid_sh[1];
                        sid_sh  <= sid_sh << 1;
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                TX_ADDR: begin
                    if (bit_cnt == '0) begin
                        if (rd_wrt) begin
                            sdo     <= data_sh[DATA_WIDTH-1];
                            data_sh <= data_sh << 1;
                            bit_cnt <= BC_W'(DATA_WIDTH - 1);
                            state   <= TX_DATA;
                        end else begin
                            sdo_en <= 1'b0;
                            cnt    <= '0;
                            state  <= WAIT_RD;
                        end
                    end else begin
                        sdo     <= addr_sh[ADDRESS_WIDTH-1];
                        addr_sh <= addr_sh << 1;
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bit_cnt == '0) begin
                        sdo_en <= 1'b0;
                        cnt    <= '0;
                        state  <= WAIT_WR;
                    end else begin
                        sdo     <= data_sh[DATA_WIDTH-1];
                        data_sh <= data_sh << 1;
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                WAIT_WR, WAIT_RD: begin
                    // if() on an X/Z line takes the else path, so an undriven line reads as idle.
                    if (slave_busy) begin
                        if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            timeout_err <= 1'b1;
                            rd_wrt      <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (state == WAIT_WR) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        sb_drv <= 1'b1;
                        state  <= HANDSHAKE;
                    end
                end
                HANDSHAKE: begin
                    sb_drv <= 1'b0;
                    cnt    <= '0;
                    state  <= RX_DATA;
                end
                RX_DATA: begin
                    if (cnt >= CNT_W'(RX_LATENCY - 1)) begin
                        rx_sh <= rx_next[DATA_WIDTH-2:0];
                    end
                    if (cnt == CNT_W'(RX_LAST)) begin
                        rd_data <= rx_next;
                        done    <= 1'b1;
                        state   <= FINISH;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        rd_wrt      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FINISH: begin
                    busy   <= 1'b0;
                    rd_wrt <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    rd_wrt <= 1'b0;
                    sdo_en <= 1'b0;
                    sb_drv <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_master.sv
// tb/tb_serial_bus_master.sv - directed bench for serial_bus_master
module tb_serial_bus_master;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        cmd_rd_wrt;
    logic [1:0]  cmd_slave_id;
    logic [14:0] cmd_addr;
    logic [7:0]  cmd_wr_data;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [7:0]  rd_data;
    logic        bus_req;
    logic        rd_wrt;
    wire         data_bus_serial;
    wire         slave_busy;

    logic        dbs_en;
    logic        dbs_val;
    logic        sb_en;

    int errors = 0;
    int checks = 0;
    int breq_cnt = 0;
    int done_cnt = 0;

    // Serial line floats high when released so a released line is distinguishable
    // from a driven 0; the busy line has the board pull-down.
    pullup   (data_bus_serial);
    pulldown (slave_busy);
    assign data_bus_serial = dbs_en ? dbs_val : 1'bz;
    assign slave_busy      = sb_en ? 1'b1 : 1'bz;

    serial_bus_master dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .cmd_rd_wrt      (cmd_rd_wrt),
        .cmd_slave_id    (cmd_slave_id),
        .cmd_addr        (cmd_addr),
        .cmd_wr_data     (cmd_wr_data),
        .busy            (busy),
        .done            (done),
        .timeout_err     (timeout_err),
        .rd_data         (rd_data),
        .bus_req         (bus_req),
        .rd_wrt          (rd_wrt),
        .data_bus_serial (data_bus_serial),
        .slave_busy      (slave_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_req === 1'b1) breq_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic rw, input logic [1:0] id, input logic [14:0] addr,
                            input logic [7:0] wd);
        cmd_rd_wrt   = rw;
        cmd_slave_id = id;
        cmd_addr     = addr;
        cmd_wr_data  = wd;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // Checks serial bits on cycles T<from>..T<n>; bit on T1 is vec[n-1].
    task automatic check_tx(input string tag, input logic [24:0] vec, input int n, input int from);
        for (int i = from; i <= n; i++) begin
            tick();
            chk($sformatf("%s_T%0d", tag, i), 32'(data_bus_serial), 32'(vec[n-i]));
        end
    endtask

    initial begin
        logic [7:0] rx_byte;
        int         to_cycle;
        int         done_before;

        rstn = 1'b0; start = 1'b0; cmd_rd_wrt = 1'b0; cmd_slave_id = 2'b00;
        cmd_addr = '0; cmd_wr_data = '0; dbs_en = 1'b0; dbs_val = 1'b0; sb_en = 1'b0;
        tick(); tick();
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_to",     32'(timeout_err), 32'd0);
        chk("rst_breq",   32'(bus_req), 32'd0);
        chk("rst_rdwrt",  32'(rd_wrt), 32'd0);
        chk("rst_rddata", 32'(rd_data), 32'd0);
        chk("rst_dbs",    32'(data_bus_serial), 32'd1);
        chk("rst_sb",     32'(slave_busy), 32'd0);
        rstn = 1'b1;
        tick();

        // Write 2'b10 / 15'h1234 / 8'hA5, slave releases busy after 3 wait cycles.
        send_cmd(1'b1, 2'b10, 15'h1234, 8'hA5);
        chk("wr_T0_breq",  32'(bus_req), 32'd1);
        chk("wr_T0_busy",  32'(busy), 32'd1);
        chk("wr_T0_rdwrt", 32'(rd_wrt), 32'd1);
        sb_en = 1'b1;
        check_tx("wr", {2'b10, 15'h1234, 8'hA5}, 25, 1);
        tick(); tick(); tick();
        chk("wr_T28_done", 32'(done), 32'd0);
        tick();
        sb_en = 1'b0;
        chk("wr_T29_done", 32'(done), 32'd0);
        chk("wr_T29_busy", 32'(busy), 32'd1);
        tick();
        chk("wr_T30_done", 32'(done), 32'd1);
        chk("wr_T30_busy", 32'(busy), 32'd1);
        tick();
        chk("wr_T31_done",  32'(done), 32'd0);
        chk("wr_T31_busy",  32'(busy), 32'd0);
        chk("wr_T31_rdwrt", 32'(rd_wrt), 32'd0);

        // Read 2'b01 / 15'h0007, slave returns 8'h3C.
        rx_byte = 8'h3C;
        send_cmd(1'b0, 2'b01, 15'h0007, 8'h00);
        chk("rd_T0_breq",  32'(bus_req), 32'd1);
        chk("rd_T0_rdwrt", 32'(rd_wrt), 32'd0);
        sb_en = 1'b1;
        check_tx("rd", 25'({2'b01, 15'h0007}), 17, 1);
        tick(); tick(); tick();
        sb_en = 1'b0;
        chk("rd_T20_done", 32'(done), 32'd0);
        tick();
        chk("rd_T21_hs_drive", 32'(slave_busy), 32'd1);
        tick();
        chk("rd_T22_hs_release", 32'(slave_busy), 32'd0);
        chk("rd_T22_dbs_free",   32'(data_bus_serial), 32'd1);
        for (int b = 7; b >= 0; b--) begin
            tick();
            dbs_en  = 1'b1;
            dbs_val = rx_byte[b];
        end
        chk("rd_T30_rddata_old", 32'(rd_data), 32'd0);
        chk("rd_T30_done",       32'(done), 32'd0);
        tick();
        dbs_en = 1'b0;
        chk("rd_T31_done",   32'(done), 32'd1);
        chk("rd_T31_rddata", 32'(rd_data), 32'h3C);
        chk("rd_T31_busy",   32'(busy), 32'd1);
        tick();
        chk("rd_T32_done",   32'(done), 32'd0);
        chk("rd_T32_busy",   32'(busy), 32'd0);
        chk("rd_T32_rddata", 32'(rd_data), 32'h3C);

        // Read with slave_busy stuck high: abort after 255 wait cycles (T18..T272).
        done_before = done_cnt;
        send_cmd(1'b0, 2'b11, 15'h0100, 8'h00);
        sb_en = 1'b1;
        to_cycle = 0;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (timeout_err === 1'b1) begin
                to_cycle = i;
                break;
            end
        end
        chk("to_cycle",   32'(to_cycle), 32'd273);
        chk("to_busy",    32'(busy), 32'd1);
        chk("to_done",    32'(done), 32'd0);
        chk("to_rddata",  32'(rd_data), 32'h3C);
        chk("to_rdwrt",   32'(rd_wrt), 32'd0);
        chk("to_dbs",     32'(data_bus_serial), 32'd1);
        tick();
        sb_en = 1'b0;
        chk("to_pulse_end", 32'(timeout_err), 32'd0);
        chk("to_busy_end",  32'(busy), 32'd0);
        chk("to_no_done",   32'(done_cnt), 32'(done_before));
        tick();
        chk("to_sb_free", 32'(slave_busy), 32'd0);

        // Reset while cmd_addr[5] (a 0) is on the line at T12.
        send_cmd(1'b1, 2'b11, 15'h0000, 8'h5A);
        for (int i = 1; i <= 12; i++) tick();
        chk("rst_mid_drive0", 32'(data_bus_serial), 32'd0);
        chk("rst_mid_rdwrt1", 32'(rd_wrt), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_mid_dbs",    32'(data_bus_serial), 32'd1);
        chk("rst_mid_rdwrt",  32'(rd_wrt), 32'd0);
        chk("rst_mid_busy",   32'(busy), 32'd0);
        chk("rst_mid_breq",   32'(bus_req), 32'd0);
        chk("rst_mid_rddata", 32'(rd_data), 32'd0);
        tick(); tick();
        rstn = 1'b1;
        tick();

        // Fresh write; start pulses in TX_SID and FINISH are ignored; slave_busy already low.
        send_cmd(1'b1, 2'b01, 15'h7FFF, 8'hC3);
        tick();
        chk("ign_T1_bit", 32'(data_bus_serial), 32'd0);
        start = 1'b1;
        cmd_rd_wrt = 1'b0;
        tick();
        start = 1'b0;
        chk("ign_T2_rdwrt", 32'(rd_wrt), 32'd1);
        chk("ign_T2_breq",  32'(bus_req), 32'd0);
        chk("ign_T2_bit",   32'(data_bus_serial), 32'd1);
        check_tx("ign", {2'b01, 15'h7FFF, 8'hC3}, 25, 3);
        tick();
        chk("ign_T26_done", 32'(done), 32'd0);
        chk("ign_T26_busy", 32'(busy), 32'd1);
        tick();
        chk("ign_T27_done", 32'(done), 32'd1);
        cmd_rd_wrt = 1'b1; cmd_slave_id = 2'b10; cmd_addr = 15'h1234; cmd_wr_data = 8'hA5;
        start = 1'b1;
        tick();
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_idle_breq", 32'(bus_req), 32'd0);
        tick();
        start = 1'b0;
        chk("b2b_T0_breq", 32'(bus_req), 32'd1);
        chk("b2b_T0_busy", 32'(busy), 32'd1);
        check_tx("b2b", {2'b10, 15'h1234, 8'hA5}, 25, 1);
        tick();
        chk("b2b_T26_done", 32'(done), 32'd0);
        tick();
        chk("b2b_T27_done", 32'(done), 32'd1);
        chk("b2b_T27_busy", 32'(busy), 32'd1);
        tick();
        chk("b2b_T28_done", 32'(done), 32'd0);
        chk("b2b_T28_busy", 32'(busy), 32'd0);
        tick();
        chk("total_bus_req", 32'(breq_cnt), 32'd6);
        chk("total_done",    32'(done_cnt), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
